// File: rtl/config_onchip_ram_pipe.sv
// On-chip RAM Avalon-MM slave: byte-lane writes, pipelined reads with
// readdatavalid, slave-error on out-of-range words, and a zero-fill engine.
module config_onchip_ram_pipe #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DEPTH          = 10000,
  parameter int unsigned ADDR_W         = 14,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic              clken,
  input  logic              clear_req,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  output logic [1:0]        response,
  output logic              waitrequest,
  output logic              clear_busy
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam state_e RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              cmd_acc;
  logic              wr_acc;
  logic              rd_acc;

  logic              s1_vld_q;
  logic              s1_err_q;
  logic [DATA_W-1:0] s1_data_q;

  assign in_range    = (32'(address) < DEPTH);
  assign idx         = address[IDX_W-1:0];
  // Stall while reset, clearing, or globally frozen
  assign waitrequest = ~reset_n | (state_q == ST_CLEAR) | ~clken;
  assign clear_busy  = (state_q == ST_CLEAR);
  assign cmd_acc     = chipselect & (read | write) & ~waitrequest;
  assign wr_acc      = cmd_acc & write;
  assign rd_acc      = cmd_acc & read & ~write;

  // FSM state and clear counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RST_STATE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Next-state: walk the clear counter, or start a soft clear on request
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (clken) begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_addr_q == IDX_W'(DEPTH - 1)) begin
            state_d    = ST_RUN;
            clr_addr_d = '0;
          end else begin
            clr_addr_d = clr_addr_q + IDX_W'(1);
          end
        end
        ST_RUN: begin
          if (clear_req) begin
            state_d    = ST_CLEAR;
            clr_addr_d = '0;
          end
        end
        default: state_d = RST_STATE;
      endcase
    end
  end

  // Array write port shared by the clear engine and bus writes; never reset
  always_ff @(posedge clk) begin
    if (clken) begin
      if (state_q == ST_CLEAR) begin
        mem_q[clr_addr_q] <= '0;
      end else if (wr_acc && in_range) begin
        for (int unsigned i = 0; i < BE_W; i++) begin
          if (byteenable[i]) mem_q[idx][i*8 +: 8] <= writedata[i*8 +: 8];
        end
      end
    end
  end

  // First read stage: registered array read, error flag for out-of-range
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_q  <= 1'b0;
      s1_err_q  <= 1'b0;
      s1_data_q <= '0;
    end else if (clken) begin
      s1_vld_q  <= rd_acc;
      s1_err_q  <= rd_acc & ~in_range;
      s1_data_q <= (rd_acc && in_range) ? mem_q[idx] : '0;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic              s2_vld_q;
    logic              s2_err_q;
    logic [DATA_W-1:0] s2_data_q;

    // Optional output register stage
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s2_vld_q  <= 1'b0;
        s2_err_q  <= 1'b0;
        s2_data_q <= '0;
      end else if (clken) begin
        s2_vld_q  <= s1_vld_q;
        s2_err_q  <= s1_err_q;
        s2_data_q <= s1_data_q;
      end
    end

    assign readdata      = s2_data_q;
    assign readdatavalid = s2_vld_q;
    assign response      = {s2_err_q, 1'b0};
  end else begin : g_lat1
    assign readdata      = s1_data_q;
    assign readdatavalid = s1_vld_q;
    assign response      = {s1_err_q, 1'b0};
  end

endmodule
